// File: rtl/pairhmm_axi_pkg.sv
// Shared AXI read-path definitions for the Pair-HMM memory arbiters:
// FSM state encoding, AXI response codes, default widths and a small
// round-robin pointer helper.
package pairhmm_axi_pkg;

    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 512;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_RESP_W = 2;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

    // One outstanding burst: arbitrate, issue the address, stream the data.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_state_t;

    // Next round-robin start position after index idx among n requesters.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr, wrapping past NUM_REQ-1 back to 0. Shared with the write path.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // Scan from the farthest offset down to ptr so the closest request wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                grant       = '0;
                grant[idx]  = 1'b1;
                grant_idx   = IDX_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read port (AR + R) among NUM_REQ Pair-HMM read engines.
// Round-robin arbitration, one outstanding burst, grant held until RLAST.
// AR outputs are registered; the R path is a zero-latency pass-through
// steered to the granted requester only.
// Optional feature: define RD_ERR_CNT_EN to add a saturating 16-bit error
// beat counter (err_cnt) with a synchronous clear input (err_clr).
module axi_rd_arbiter
    import pairhmm_axi_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = AXI_ADDR_W,
    parameter int DATA_W  = AXI_DATA_W,
    parameter int LEN_W   = AXI_LEN_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // requester side
    input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_arlen,
    input  logic [NUM_REQ-1:0]        req_arvalid,
    output logic [NUM_REQ-1:0]        req_arready,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [1:0]                req_rresp,
    output logic                      req_rlast,
    output logic [NUM_REQ-1:0]        req_rvalid,
    input  logic [NUM_REQ-1:0]        req_rready,
    // DDR side
    output logic [ADDR_W-1:0]         ARADDR,
    output logic [LEN_W-1:0]          ARLEN,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [DATA_W-1:0]         RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY,
    output logic                      busy
`ifdef RD_ERR_CNT_EN
    ,
    output logic [15:0]               err_cnt,
    input  logic                      err_clr
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rd_state_t            state_reg;
    logic [IDX_W-1:0]     grant_reg;
    logic [IDX_W-1:0]     rr_ptr_reg;

    logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
    logic [LEN_W-1:0]     len_arr  [NUM_REQ];

    logic [NUM_REQ-1:0]   win_onehot;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_valid;

    logic                 in_idle;
    logic                 in_data;
    logic                 r_last_hs;

    // Unpack the flat requester buses into per-requester views.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_araddr[gi*ADDR_W +: ADDR_W];
            assign len_arr[gi]  = req_arlen[gi*LEN_W +: LEN_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req_arvalid),
        .ptr         (rr_ptr_reg),
        .grant       (win_onehot),
        .grant_idx   (win_idx),
        .grant_valid (win_valid)
    );

    assign in_idle   = (state_reg == IDLE);
    assign in_data   = (state_reg == DATA);
    assign r_last_hs = RVALID && RREADY && RLAST;

    // Accept pulse only while idle; held low while reset is asserted.
    assign req_arready = (in_idle && rst_n) ? win_onehot : '0;

    // R path: data/resp/last broadcast, valid steered to the grant only.
    assign req_rdata = RDATA;
    assign req_rresp = RRESP;
    assign req_rlast = RLAST;
    assign RREADY    = in_data ? req_rready[grant_reg] : 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
            assign req_rvalid[gi] = in_data && RVALID && (grant_reg == IDX_W'(gi));
        end
    endgenerate

    // Arbitration FSM with registered AR channel and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            ARADDR     <= '0;
            ARLEN      <= '0;
            ARVALID    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        grant_reg <= win_idx;
                        ARADDR    <= addr_arr[win_idx];
                        ARLEN     <= len_arr[win_idx];
                        ARVALID   <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= ADDR;
                    end else begin
                        // Nothing pending: keep the DDR-side outputs quiet.
                        ARADDR    <= '0;
                        ARLEN     <= '0;
                        ARVALID   <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        ARVALID   <= 1'b0;
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (r_last_hs) begin
                        rr_ptr_reg <= IDX_W'(rr_wrap_inc(int'(grant_reg), NUM_REQ));
                        busy       <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    ARVALID   <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef RD_ERR_CNT_EN
    // Count accepted error beats, saturating; a clear wins over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (RVALID && RREADY && (RRESP != RESP_OKAY) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: randomized requesters and DDR
// responder against a transaction-level round-robin reference model.
module tb_axi_rd_arbiter;
    import pairhmm_axi_pkg::*;

    localparam int N  = 3;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*AW-1:0]   req_araddr;
    logic [N*LW-1:0]   req_arlen;
    logic [N-1:0]      req_arvalid;
    logic [N-1:0]      req_arready;
    logic [DW-1:0]     req_rdata;
    logic [1:0]        req_rresp;
    logic              req_rlast;
    logic [N-1:0]      req_rvalid;
    logic [N-1:0]      req_rready;
    logic [AW-1:0]     ARADDR;
    logic [LW-1:0]     ARLEN;
    logic              ARVALID;
    logic              ARREADY;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;
    logic              busy;
`ifdef RD_ERR_CNT_EN
    logic [15:0]       err_cnt;
    logic              err_clr;
`endif

    axi_rd_arbiter #(
        .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .LEN_W (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_araddr  (req_araddr),
        .req_arlen   (req_arlen),
        .req_arvalid (req_arvalid),
        .req_arready (req_arready),
        .req_rdata   (req_rdata),
        .req_rresp   (req_rresp),
        .req_rlast   (req_rlast),
        .req_rvalid  (req_rvalid),
        .req_rready  (req_rready),
        .ARADDR      (ARADDR),
        .ARLEN       (ARLEN),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RLAST       (RLAST),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .busy        (busy)
`ifdef RD_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt),
        .err_clr     (err_clr)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    int           exp_ptr = 0;
    int           exp_err = 0;
    bit           pend_v [N];
    logic [AW-1:0] pend_a [N];
    logic [LW-1:0] pend_l [N];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_arvalid[i]          = pend_v[i];
            req_araddr[i*AW +: AW]  = pend_a[i];
            req_arlen[i*LW +: LW]   = pend_l[i];
        end
    endtask

    task automatic new_req(input int i);
        pend_v[i] = 1'b1;
        pend_a[i] = {$urandom, $urandom} & ~64'h3F;
        pend_l[i] = LW'($urandom_range(0, 7));
    endtask

    // Round-robin rule: first pending requester at or after the pointer.
    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (pend_v[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int j = 0; j < DW/32; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0; pend_a[i] = '0; pend_l[i] = '0;
        end
        drive_reqs();
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = '0;
        req_rready = '0;
`ifdef RD_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst_arvalid", DW'(ARVALID), DW'(0));
        chk("rst_araddr", DW'(ARADDR), DW'(0));
        chk("rst_arlen", DW'(ARLEN), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_arready", DW'(req_arready), DW'(0));
        chk("rst_rvalid", DW'(req_rvalid), DW'(0));
        chk("rst_rready", DW'(RREADY), DW'(0));
`ifdef RD_ERR_CNT_EN
        chk("rst_err_cnt", DW'(err_cnt), DW'(0));
`endif
        rst_n = 1'b1;
        exp_ptr = 0;
        exp_err = 0;
        tick();
        // A stray beat while idle must be ignored.
        RVALID = 1'b1; RLAST = 1'b1; req_rready = '1;
        #1;
        chk("stray_rready", DW'(RREADY), DW'(0));
        chk("stray_rvalid", DW'(req_rvalid), DW'(0));
        tick();
        chk("stray_busy", DW'(busy), DW'(0));
        chk("stray_arvalid", DW'(ARVALID), DW'(0));
        RVALID = 1'b0; RLAST = 1'b0; req_rready = '0;
    endtask

    // One complete burst from the current idle cycle through the RLAST beat.
    // rmode: 0 random RVALID/rready, 1 RVALID high and rready toggling, 2 both high.
    task automatic do_burst(input int ar_stall, input int rmode, input logic [N-1:0] refill,
                            input int err_pat, output int won);
        int            w, waited, dd, cyc, nb;
        logic [AW-1:0] ea;
        logic [LW-1:0] el;
        logic [DW-1:0] bd[$];
        logic [1:0]    br[$];
        logic          rr;
        w = pick();
        won = -1;
        drive_reqs();
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
        #1;
        waited = 0;
        while (req_arready == '0 && waited < 20) begin
            tick(); drive_reqs(); #1; waited++;
        end
        chk("accept_wait", DW'(waited), DW'(0));
        chk("arready", DW'(req_arready), DW'(onehot(w)));
        chk("arvalid_idle", DW'(ARVALID), DW'(0));
        won = first_set(req_arready);
        if (w < 0) return;
        ea = pend_a[w];
        el = pend_l[w];
        tick();
        pend_v[w] = 1'b0;
        if (refill[w]) new_req(w);
        for (int c = 0; c <= ar_stall; c++) begin
            drive_reqs();
            ARREADY = (c == ar_stall);
            #1;
            chk("arvalid", DW'(ARVALID), DW'(1));
            chk("araddr", DW'(ARADDR), DW'(ea));
            chk("arlen", DW'(ARLEN), DW'(el));
            chk("busy_addr", DW'(busy), DW'(1));
            chk("arready_busy", DW'(req_arready), DW'(0));
            tick();
        end
        ARREADY = 1'b0;
        nb = int'(el) + 1;
        for (int k = 0; k < nb; k++) begin
            bd.push_back(rand_beat());
            if (err_pat < 0) br.push_back(($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY);
            else br.push_back((k < 32 && ((err_pat >> k) & 1) != 0) ? RESP_SLVERR : RESP_OKAY);
        end
        dd = 0;
        cyc = 0;
        while (dd < nb && cyc < 300) begin
            drive_reqs();
            case (rmode)
                0: begin RVALID = ($urandom_range(0, 3) != 0); rr = 1'($urandom_range(0, 1)); end
                1: begin RVALID = 1'b1; rr = (cyc % 2 == 0); end
                default: begin RVALID = 1'b1; rr = 1'b1; end
            endcase
            for (int i = 0; i < N; i++) req_rready[i] = 1'($urandom_range(0, 1));
            req_rready[w] = rr;
            RDATA = bd[dd];
            RRESP = br[dd];
            RLAST = (dd == nb - 1);
            #1;
            chk("arvalid_data", DW'(ARVALID), DW'(0));
            chk("rready_mirror", DW'(RREADY), DW'(rr));
            chk("rvalid_route", DW'(req_rvalid), DW'(RVALID ? onehot(w) : '0));
            chk("rdata_pass", req_rdata, bd[dd]);
            chk("rresp_pass", DW'(req_rresp), DW'(br[dd]));
            chk("rlast_pass", DW'(req_rlast), DW'(dd == nb - 1));
            chk("busy_data", DW'(busy), DW'(1));
            if (RVALID && rr) begin
                if (br[dd] != RESP_OKAY && exp_err < 65535) exp_err++;
                dd++;
            end
            tick();
            cyc++;
        end
        chk("beat_count", DW'(dd), DW'(nb));
        RVALID = 1'b0; RLAST = 1'b0; req_rready = '0;
        exp_ptr = (w + 1) % N;
        drive_reqs();
        #1;
        chk("busy_after", DW'(busy), DW'(0));
        chk("rvalid_after", DW'(req_rvalid), DW'(0));
        chk("arvalid_after", DW'(ARVALID), DW'(0));
`ifdef RD_ERR_CNT_EN
        chk("err_cnt_track", DW'(err_cnt), DW'(exp_err));
`endif
    endtask

    task automatic drop_all();
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        drive_reqs();
        #1;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int won;
        do_reset();

        // Single requester 0, addr 0x1000, 4 beats.
        pend_v[0] = 1'b1; pend_a[0] = 64'h1000; pend_l[0] = 8'd3;
        do_burst(0, 2, 3'b000, 0, won);
        chk("single_winner", DW'(won), DW'(0));
        drop_all();

        // All three at once from reset, single-beat bursts: 0,1,2 then 0 alone.
        do_reset();
        for (int i = 0; i < N; i++) begin
            new_req(i);
            pend_l[i] = 8'd0;
        end
        for (int k = 0; k < N; k++) begin
            do_burst(0, 2, 3'b000, 0, won);
            chk("rr_order", DW'(won), DW'(k));
        end
        new_req(0);
        do_burst(0, 2, 3'b000, 0, won);
        chk("rr_wrap", DW'(won), DW'(0));

        // Requesters 1 and 2 re-request continuously: strict alternation.
        new_req(1);
        new_req(2);
        for (int it = 0; it < 20; it++) begin
            do_burst(0, 2, 3'b110, 0, won);
            chk("alternate", DW'(won), DW'((it % 2 == 0) ? 1 : 2));
        end
        drop_all();

        // Address channel stalled for 5 cycles.
        new_req(1);
        do_burst(5, 2, 3'b000, 0, won);
        drop_all();

        // Eight beats with rready toggling every other cycle.
        new_req(0);
        pend_l[0] = 8'd7;
        do_burst(0, 1, 3'b000, 0, won);
        drop_all();

`ifdef RD_ERR_CNT_EN
        // Error beats 2 and 3 of a 4-beat burst, then clear.
        new_req(2);
        pend_l[2] = 8'd3;
        do_burst(0, 2, 3'b000, 32'b0110, won);
        chk("err_cnt_two", DW'(err_cnt), DW'(2));
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_err = 0;
        chk("err_cnt_clr", DW'(err_cnt), DW'(0));
`endif

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) if (!pend_v[i] && $urandom_range(0, 1) == 1) new_req(i);
            if (pick() < 0) new_req(int'($urandom_range(0, N - 1)));
            do_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), '0, -1, won);
        end
        drop_all();

        // Reset asserted in the middle of a burst.
        new_req(2);
        drive_reqs();
        ARREADY = 1'b1;
        #1;
        tick();
        pend_v[2] = 1'b0;
        drive_reqs();
        tick();
        ARREADY = 1'b0; RVALID = 1'b1; RLAST = 1'b0; req_rready = '1; RDATA = rand_beat();
        #1;
        chk("midrst_pre_rvalid", DW'(req_rvalid), DW'(onehot(2)));
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", DW'(busy), DW'(0));
        chk("midrst_rvalid", DW'(req_rvalid), DW'(0));
        chk("midrst_rready", DW'(RREADY), DW'(0));
        chk("midrst_arvalid", DW'(ARVALID), DW'(0));
        tick();
        RVALID = 1'b0; req_rready = '0;
        rst_n = 1'b1;
        exp_ptr = 0;
        exp_err = 0;
        tick();
        for (int i = 0; i < N; i++) new_req(i);
        do_burst(0, 2, 3'b000, 0, won);
        chk("midrst_ptr_reset", DW'(won), DW'(0));
        drop_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
